// File: rtl/img_rle_pkg.sv
// Shared constants, FSM state codes and the run-word layout for the RLE image decoder.
package img_rle_pkg;

  localparam int unsigned IMG_W       = 128;
  localparam int unsigned IMG_H       = 128;
  localparam int unsigned WORD_W      = 16;
  localparam int unsigned RUN_W       = 15;
  localparam int unsigned IMG_PIXELS  = IMG_W * IMG_H;
  localparam int unsigned PIX_CNT_W   = $clog2(IMG_PIXELS);
  localparam int unsigned WORD_ADDR_W = $clog2(IMG_PIXELS / WORD_W);
  localparam int unsigned BIT_SEL_W   = $clog2(WORD_W);
  localparam int unsigned RUN_DATA_W  = RUN_W + 1;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_LOAD = 2'd1;
  localparam state_t ST_FILL = 2'd2;
  localparam state_t ST_DONE = 2'd3;

  // Run word: [15] pixel value, [14:0] run length
  typedef struct packed {
    logic             value;
    logic [RUN_W-1:0] len;
  } run_word_t;

endpackage

// File: rtl/img_word_packer.sv
// Packs the serial pixel stream into 16-pixel words (first pixel in the MSB)
// and registers the image-buffer write strobe, address and data.
module img_word_packer
  import img_rle_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_pixel,
  input  logic                   i_pixel_valid,
  input  logic [PIX_CNT_W-1:0]   i_pix_cnt,
  output logic                   o_img_we,
  output logic [WORD_ADDR_W-1:0] o_img_addr,
  output logic [WORD_W-1:0]      o_img_wdata
);

  logic [WORD_W-1:0]      r_pack;
  logic                   r_img_we;
  logic [WORD_ADDR_W-1:0] r_img_addr;
  logic [WORD_W-1:0]      r_img_wdata;

  logic [BIT_SEL_W-1:0]   w_bit;
  logic [WORD_W-1:0]      w_word;
  logic                   w_word_end;

  assign w_bit      = i_pix_cnt[BIT_SEL_W-1:0];
  assign w_word_end = i_pixel_valid && (w_bit == BIT_SEL_W'(WORD_W - 1));

  // Current word with the incoming pixel inserted at bit 15-(p&15)
  always_comb begin
    w_word = r_pack;
    w_word[BIT_SEL_W'(WORD_W - 1) - w_bit] = i_pixel;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pack      <= '0;
      r_img_we    <= 1'b0;
      r_img_addr  <= '0;
      r_img_wdata <= '0;
    end else begin
      r_img_we <= w_word_end;
      if (w_word_end) begin
        r_pack      <= '0;
        r_img_addr  <= i_pix_cnt[PIX_CNT_W-1:BIT_SEL_W];
        r_img_wdata <= w_word;
      end else if (i_pixel_valid) begin
        r_pack <= w_word;
      end
    end
  end

  assign o_img_we    = r_img_we;
  assign o_img_addr  = r_img_addr;
  assign o_img_wdata = r_img_wdata;

endmodule

// File: rtl/img_rle_decoder.sv
// Run-length decoder filling the 128x128 binary image buffer, one pixel per FILL cycle.
// Optional macro RLE_ERR_EN enables the sticky truncation (overflow) flag on err.
module img_rle_decoder
  import img_rle_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   run_valid,
  output logic                   run_ready,
  input  logic [RUN_DATA_W-1:0]  run_data,
  output logic                   img_we,
  output logic [WORD_ADDR_W-1:0] img_addr,
  output logic [WORD_W-1:0]      img_wdata,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);

  state_t               r_state;
  logic [PIX_CNT_W-1:0] r_pix_cnt;
  logic [RUN_W-1:0]     r_rem;
  logic                 r_value;
  logic                 r_run_ready;
  logic                 r_busy;
  logic                 r_done;

  state_t               w_state_nxt;
  logic [PIX_CNT_W-1:0] w_pix_cnt_nxt;
  logic [RUN_W-1:0]     w_rem_nxt;
  logic                 w_value_nxt;
  logic                 w_accept;
  logic                 w_start_acc;
  logic                 w_last_pix;
  run_word_t            w_run;

  assign w_run       = run_word_t'(run_data);
  assign w_accept    = run_valid && r_run_ready;
  assign w_start_acc = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_last_pix  = (r_pix_cnt == PIX_CNT_W'(IMG_PIXELS - 1));

  always_comb begin
    w_state_nxt   = r_state;
    w_pix_cnt_nxt = r_pix_cnt;
    w_rem_nxt     = r_rem;
    w_value_nxt   = r_value;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (w_start_acc) begin
          w_state_nxt   = ST_LOAD;
          w_pix_cnt_nxt = '0;
          w_rem_nxt     = '0;
        end
      end
      ST_LOAD: begin
        // Zero-length runs are consumed without leaving LOAD
        if (w_accept) begin
          w_value_nxt = w_run.value;
          if (w_run.len != '0) begin
            w_rem_nxt   = w_run.len;
            w_state_nxt = ST_FILL;
          end
        end
      end
      ST_FILL: begin
        w_pix_cnt_nxt = r_pix_cnt + PIX_CNT_W'(1);
        w_rem_nxt     = r_rem - RUN_W'(1);
        if (w_last_pix) begin
          w_state_nxt = ST_DONE;
          w_rem_nxt   = '0;
        end else if (r_rem == RUN_W'(1)) begin
          w_state_nxt = ST_LOAD;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_pix_cnt   <= '0;
      r_rem       <= '0;
      r_value     <= 1'b0;
      r_run_ready <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_pix_cnt   <= w_pix_cnt_nxt;
      r_rem       <= w_rem_nxt;
      r_value     <= w_value_nxt;
      r_run_ready <= (w_state_nxt == ST_LOAD);
      r_busy      <= (w_state_nxt == ST_LOAD) || (w_state_nxt == ST_FILL);
      r_done      <= (w_state_nxt == ST_DONE);
    end
  end

  img_word_packer u_packer (
    .clk           (clk),
    .rst           (rst),
    .i_pixel       (r_value),
    .i_pixel_valid (r_state == ST_FILL),
    .i_pix_cnt     (r_pix_cnt),
    .o_img_we      (img_we),
    .o_img_addr    (img_addr),
    .o_img_wdata   (img_wdata)
  );

`ifdef RLE_ERR_EN
  logic r_err;
  logic w_trunc;

  // Run still had pixels left when the final pixel was placed
  assign w_trunc = (r_state == ST_FILL) && w_last_pix && (r_rem > RUN_W'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)              r_err <= 1'b0;
    else if (w_start_acc) r_err <= 1'b0;
    else if (w_trunc)     r_err <= 1'b1;
  end

  assign err = r_err;
`else
  assign err = 1'b0;
`endif

  assign run_ready = r_run_ready;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

// File: tb/tb_img_rle_decoder.sv
// Self-checking bench for img_rle_decoder: image model built from the run list,
// per-cycle write checks, latency and truncation checks.
module tb_img_rle_decoder;

  localparam int NPIX  = 16384;
  localparam int NWORD = 1024;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        run_valid;
  logic        run_ready;
  logic [15:0] run_data;
  logic        img_we;
  logic [9:0]  img_addr;
  logic [15:0] img_wdata;
  logic        busy;
  logic        done;
  logic        err;

  always #5 clk = ~clk;

  img_rle_decoder dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .run_valid (run_valid),
    .run_ready (run_ready),
    .run_data  (run_data),
    .img_we    (img_we),
    .img_addr  (img_addr),
    .img_wdata (img_wdata),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  int          n_total = 0;
  int          n_pass  = 0;
  logic [15:0] runs_q[$];
  logic        exp_pix  [NPIX];
  logic [15:0] exp_word [NWORD];
  logic [15:0] got_word [NWORD];
  int          exp_addr, exp_z, exp_n, exp_left;
  logic        exp_trunc;
  int          gap_max, gap_left, total_gap, cyc, lat;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, required %0h", name, act, req);
  endtask

  // Expected image, run counts and truncation straight from the run list
  task automatic build_model();
    int p;
    int len;
    int take;
    p = 0; exp_z = 0; exp_n = 0; exp_left = 0; exp_trunc = 1'b0;
    for (int i = 0; i < NPIX; i++) exp_pix[i] = 1'b0;
    for (int i = 0; i < runs_q.size(); i++) begin
      if (p >= NPIX) begin
        exp_left++;
        continue;
      end
      len = int'(runs_q[i][14:0]);
      if (len == 0) exp_z++; else exp_n++;
      take = (len < NPIX - p) ? len : NPIX - p;
      if (len > take) exp_trunc = 1'b1;
      for (int j = 0; j < take; j++) exp_pix[p + j] = runs_q[i][15];
      p += take;
    end
    for (int k = 0; k < NWORD; k++)
      for (int b = 0; b < 16; b++) exp_word[k][15-b] = exp_pix[16*k + b];
    for (int k = 0; k < NWORD; k++) got_word[k] = 16'hDEAD;
  endtask

  // One clock: feed the stream, then check any write against the model
  task automatic step();
    logic hs;
    hs = run_valid && run_ready;
    @(posedge clk);
    #1;
    cyc++;
    if (hs) begin
      void'(runs_q.pop_front());
      gap_left = (gap_max > 0) ? int'($urandom_range(32'(gap_max), 0)) : 0;
    end
    if (run_ready && gap_left > 0 && runs_q.size() > 0) begin
      run_valid = 1'b0;
      gap_left--;
      total_gap++;
    end else begin
      run_valid = (runs_q.size() > 0);
      run_data  = (runs_q.size() > 0) ? runs_q[0] : 16'h0000;
    end
    if (img_we) begin
      if (exp_addr < NWORD) begin
        check("wr_addr", 32'(img_addr), 32'(exp_addr));
        check("wr_data", 32'(img_wdata), 32'(exp_word[exp_addr]));
        got_word[exp_addr] = img_wdata;
      end else begin
        check("write_count_overrun", 32'(exp_addr), 32'(NWORD - 1));
      end
      exp_addr++;
    end
  endtask

  task automatic run_scn(input string nm, input int gmax, input int start_mid);
    int budget;
    build_model();
    gap_max   = gmax;
    gap_left  = (gmax > 0) ? int'($urandom_range(32'(gmax), 0)) : 0;
    total_gap = 0;
    exp_addr  = 0;
    start = 1'b1; run_valid = 1'b0;
    step();
    start = 1'b0;
    cyc = 0;
    check({nm, " busy_after_start"}, 32'(busy), 32'd1);
    check({nm, " done_cleared"}, 32'(done), 32'd0);
    budget = 0;
    while (!done && budget < 40000) begin
      start = (start_mid > 0 && cyc == start_mid);
      step();
      budget++;
    end
    start = 1'b0;
    lat = cyc + 1;
    if (!done) begin
      check({nm, " done_timeout"}, 32'(done), 32'd1);
    end else begin
      check({nm, " latency"}, 32'(lat), 32'(1 + exp_z + exp_n + NPIX + total_gap));
      check({nm, " last_we_with_done"}, 32'(img_we), 32'd1);
      check({nm, " busy_at_done"}, 32'(busy), 32'd0);
`ifdef RLE_ERR_EN
      check({nm, " err"}, 32'(err), 32'(exp_trunc));
`else
      check({nm, " err"}, 32'(err), 32'd0);
`endif
    end
    check({nm, " write_count"}, 32'(exp_addr), 32'(NWORD));
    repeat (4) step();
    check({nm, " ready_after_done"}, 32'(run_ready), 32'd0);
    check({nm, " done_held"}, 32'(done), 32'd1);
    check({nm, " unconsumed_words"}, 32'(runs_q.size()), 32'(exp_left));
    check({nm, " no_late_write"}, 32'(exp_addr), 32'(NWORD));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; run_valid = 1'b0; run_data = 16'h0000;
    cyc = 0; gap_max = 0; gap_left = 0; total_gap = 0; exp_addr = 0; lat = 0;
    #3;
    check("rst run_ready", 32'(run_ready), 32'd0);
    check("rst img_we", 32'(img_we), 32'd0);
    check("rst img_addr", 32'(img_addr), 32'd0);
    check("rst img_wdata", 32'(img_wdata), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst err", 32'(err), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    step();
    check("idle run_ready", 32'(run_ready), 32'd0);

    // Single full-image run of ones
    runs_q = {16'hC000};
    run_scn("single", 0, 0);
    check("single lat_literal", 32'(lat), 32'd16386);
    check("single word0", 32'(got_word[0]), 32'h0000FFFF);
    check("single word1023", 32'(got_word[1023]), 32'h0000FFFF);

    // Alternating 8-pixel runs; a start pulse mid-decode must be ignored
    runs_q = {};
    for (int i = 0; i < 2048; i++) runs_q.push_back((i % 2 == 1) ? 16'h8008 : 16'h0008);
    run_scn("alt8", 0, 50);
    check("alt8 lat_literal", 32'(lat), 32'd18433);
    check("alt8 word517", 32'(got_word[517]), 32'h000000FF);

    // Zero-length run is skipped
    runs_q = {16'h0005, 16'h8000, 16'h8003, 16'h3FF8};
    run_scn("zero_run", 0, 0);
    check("zero_run word0", 32'(got_word[0]), 32'h00000700);
    check("zero_run word1", 32'(got_word[1]), 32'h00000000);
    check("zero_run lat_literal", 32'(lat), 32'd16389);

    // Overflow: second run truncated, third word left unconsumed
    runs_q = {16'h3E80, 16'h83E8, 16'h8005};
    run_scn("overflow", 0, 0);
    check("overflow word999", 32'(got_word[999]), 32'h00000000);
    check("overflow word1000", 32'(got_word[1000]), 32'h0000FFFF);
    check("overflow word1023", 32'(got_word[1023]), 32'h0000FFFF);
    check("overflow left_count", 32'(runs_q.size()), 32'd1);
    if (runs_q.size() > 0) check("overflow left_word", 32'(runs_q[0]), 32'h00008005);
`ifdef RLE_ERR_EN
    check("overflow err_literal", 32'(err), 32'd1);
`else
    check("overflow err_literal", 32'(err), 32'd0);
`endif

    // Reset in the middle of FILL, right after pixel 100 is placed
    runs_q = {16'hC000};
    build_model();
    gap_max = 0; gap_left = 0; exp_addr = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    cyc = 0;
    while (cyc < 102) step();
    #1 rst = 1'b1;
    #1;
    check("midrst run_ready", 32'(run_ready), 32'd0);
    check("midrst img_we", 32'(img_we), 32'd0);
    check("midrst img_addr", 32'(img_addr), 32'd0);
    check("midrst img_wdata", 32'(img_wdata), 32'd0);
    check("midrst busy", 32'(busy), 32'd0);
    check("midrst done", 32'(done), 32'd0);
    check("midrst err", 32'(err), 32'd0);
    check("midrst words_before", 32'(exp_addr), 32'd6);
    repeat (3) step();
    rst = 1'b0;
    repeat (20) step();
    check("midrst no_write_after", 32'(exp_addr), 32'd6);
    check("midrst idle_busy", 32'(busy), 32'd0);

    // Restart after reset, with random input gaps before each run word
    runs_q = {16'hC000};
    run_scn("gaps_single", 40, 0);

    runs_q = {16'h0005, 16'h8000, 16'h8003, 16'h3FF8};
    run_scn("gaps_zero_run", 9, 0);
    check("gaps_zero_run word0", 32'(got_word[0]), 32'h00000700);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
